afifo_wr_packer: RTL and testbench

AFIFO_WR_PACKER -- requirements
Module: afifo_wr_packer

---
 rtl/afifo_wr_packer.sv | 112 +++++++++++
 tb/tb_afifo_wr_packer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_wr_packer.sv
// Packs narrow upstream beats into wide async-FIFO write words with per-lane keep.
// An accumulator and one output register form a two-word skid so a full beat stream flows without bubbles.
module afifo_wr_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      i_clk_wr,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [IN_WIDTH-1:0]       i_data,
  input  logic                      i_last,
  input  logic                      i_flush,
  output logic                      o_wr_en,
  output logic [IN_WIDTH*RATIO-1:0] o_wr_data,
  output logic [RATIO-1:0]          o_wr_keep,
  input  logic                      i_full,
  output logic [15:0]               o_word_cnt,
  output logic                      o_busy
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]     acc_cnt, acc_cnt_nxt, lane;
  logic [OUT_WIDTH-1:0] acc_data, acc_data_nxt;
  logic [RATIO-1:0]     acc_keep, acc_keep_nxt;
  logic                 acc_done, acc_done_nxt;

  logic [OUT_WIDTH-1:0] out_data;
  logic [RATIO-1:0]     out_keep;
  logic                 out_pend;
  logic [15:0]          word_cnt;

  logic accept, move, wr_en;

  assign wr_en   = out_pend & ~i_full;
  assign move    = acc_done & (~out_pend | wr_en);
  assign o_ready = ~acc_done | move;
  assign accept  = i_valid & o_ready;

  // A move clears the accumulator first, so a beat taken in the same cycle lands in lane 0.
  always_comb begin
    acc_cnt_nxt  = acc_cnt;
    acc_data_nxt = acc_data;
    acc_keep_nxt = acc_keep;
    acc_done_nxt = acc_done;
    lane         = acc_cnt;
    if (move) begin
      acc_cnt_nxt  = '0;
      acc_data_nxt = '0;
      acc_keep_nxt = '0;
      acc_done_nxt = 1'b0;
      lane         = '0;
    end
    if (accept) begin
      for (int i = 0; i < RATIO; i++) begin
        if (lane == CNT_W'(i)) begin
          acc_data_nxt[i*IN_WIDTH +: IN_WIDTH] = i_data;
          acc_keep_nxt[i]                      = 1'b1;
        end
      end
      acc_cnt_nxt  = (lane == LAST_LANE) ? '0 : lane + CNT_W'(1);
      acc_done_nxt = (lane == LAST_LANE) | i_last | i_flush;
    end else if (i_flush && (acc_cnt != '0) && !acc_done) begin
      acc_done_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk_wr or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_cnt  <= '0;
      acc_data <= '0;
      acc_keep <= '0;
      acc_done <= 1'b0;
    end else begin
      acc_cnt  <= acc_cnt_nxt;
      acc_data <= acc_data_nxt;
      acc_keep <= acc_keep_nxt;
      acc_done <= acc_done_nxt;
    end
  end

  // The output word stays put while the FIFO is full; a write and a refill may share one edge.
  always_ff @(posedge i_clk_wr or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_data <= '0;
      out_keep <= '0;
      out_pend <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (move) begin
        out_data <= acc_data;
        out_keep <= acc_keep;
        out_pend <= 1'b1;
      end else if (wr_en) begin
        out_pend <= 1'b0;
      end
      if (wr_en) begin
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

  assign o_wr_en    = wr_en;
  assign o_wr_data  = out_data;
  assign o_wr_keep  = out_keep;
  assign o_word_cnt = word_cnt;
  assign o_busy     = (acc_cnt != '0) | acc_done | out_pend;

endmodule

// File: tb/tb_afifo_wr_packer.sv
// Self-checking bench for afifo_wr_packer: fixed vector table, corner sequences and a
// random run, all checked against a word-level model (beat lists closed into words, queued until written).
module tb_afifo_wr_packer;

  localparam int IN_WIDTH  = 8;
  localparam int RATIO     = 4;
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;

  logic                 i_clk_wr = 1'b0;
  logic                 i_rst_n;
  logic                 i_valid, i_last, i_flush, i_full;
  logic [IN_WIDTH-1:0]  i_data;
  logic                 o_ready, o_wr_en, o_busy;
  logic [OUT_WIDTH-1:0] o_wr_data;
  logic [RATIO-1:0]     o_wr_keep;
  logic [15:0]          o_word_cnt;

  always #5 i_clk_wr = ~i_clk_wr;

  afifo_wr_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
    .i_clk_wr  (i_clk_wr),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_last    (i_last),
    .i_flush   (i_flush),
    .o_wr_en   (o_wr_en),
    .o_wr_data (o_wr_data),
    .o_wr_keep (o_wr_keep),
    .i_full    (i_full),
    .o_word_cnt(o_word_cnt),
    .o_busy    (o_busy)
  );

  int checks   = 0;
  int failures = 0;

  // Closed words wait in exp_q until written; a word becomes the held output one edge after it closes.
  typedef struct {
    logic [OUT_WIDTH-1:0] data;
    logic [RATIO-1:0]     keep;
    int                   close_edge;
  } word_t;

  word_t                exp_q[$];
  int                   part_cnt;
  logic [OUT_WIDTH-1:0] part_data;
  logic [RATIO-1:0]     part_keep;
  int                   edge_no = 0;
  logic [15:0]          exp_wcnt;
  logic                 exp_ready, exp_wen;
  int                   ready_low_cycles;

  typedef struct {
    logic                 valid;
    logic [IN_WIDTH-1:0]  data;
    logic                 last;
    logic                 flush;
    logic                 full;
    logic                 exp_wen;
    logic [OUT_WIDTH-1:0] exp_data;
    logic [RATIO-1:0]     exp_keep;
    logic [15:0]          exp_cnt;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    part_cnt  = 0;
    part_data = '0;
    part_keep = '0;
    exp_wcnt  = '0;
  endtask

  task automatic closeWord();
    word_t w;
    w.data       = part_data;
    w.keep       = part_keep;
    w.close_edge = edge_no;
    exp_q.push_back(w);
    part_cnt  = 0;
    part_data = '0;
    part_keep = '0;
  endtask

  task automatic driveInputs(input logic v, input logic [IN_WIDTH-1:0] d,
                             input logic l, input logic f, input logic fu);
    @(negedge i_clk_wr);
    i_valid = v;
    i_data  = d;
    i_last  = l;
    i_flush = f;
    i_full  = fu;
    #1;
  endtask

  task automatic checkOutput();
    int   n;
    logic held;
    n         = exp_q.size();
    held      = (n > 0) && (edge_no > exp_q[0].close_edge);
    exp_ready = !((n == 2) && i_full);
    exp_wen   = held && !i_full;
    check("o_ready", o_ready, exp_ready);
    check("o_wr_en", o_wr_en, exp_wen);
    check("o_busy", o_busy, (n > 0) || (part_cnt > 0));
    check("o_word_cnt", o_word_cnt, exp_wcnt);
    if (held) begin
      check("o_wr_data", o_wr_data, exp_q[0].data);
      check("o_wr_keep", o_wr_keep, exp_q[0].keep);
    end
    if (!o_ready) ready_low_cycles++;
  endtask

  task automatic advance();
    @(posedge i_clk_wr);
    edge_no++;
    if (exp_wen) begin
      void'(exp_q.pop_front());
      exp_wcnt++;
    end
    if (i_valid && exp_ready) begin
      part_data[part_cnt*IN_WIDTH +: IN_WIDTH] = i_data;
      part_keep[part_cnt] = 1'b1;
      part_cnt++;
      if ((part_cnt == RATIO) || i_last || i_flush) closeWord();
    end else if (i_flush && (part_cnt > 0)) begin
      closeWord();
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [IN_WIDTH-1:0] d,
                               input logic l, input logic f, input logic fu);
    driveInputs(v, d, l, f, fu);
    checkOutput();
    advance();
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || part_cnt != 0) && i < budget) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      i++;
    end
    if (exp_q.size() != 0 || part_cnt != 0) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_o_ready"}, o_ready, 1'b1);
    check({tag, "_o_wr_en"}, o_wr_en, 1'b0);
    check({tag, "_o_wr_data"}, o_wr_data, '0);
    check({tag, "_o_wr_keep"}, o_wr_keep, '0);
    check({tag, "_o_word_cnt"}, o_word_cnt, '0);
    check({tag, "_o_busy"}, o_busy, 1'b0);
  endtask

  // Reset is asserted off the clock edge to exercise its asynchronous clear.
  task automatic doReset(input string tag);
    @(negedge i_clk_wr);
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_flush = 1'b0;
    i_full  = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    checkResetOutputs(tag);
    modelReset();
    repeat (2) @(posedge i_clk_wr);
    @(negedge i_clk_wr);
    i_rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic v, input logic [IN_WIDTH-1:0] d, input logic l,
                              input logic f, input logic fu, input logic ew,
                              input logic [OUT_WIDTH-1:0] ed, input logic [RATIO-1:0] ek,
                              input logic [15:0] ec);
    vec_t r;
    r.valid = v; r.data = d; r.last = l; r.flush = f; r.full = fu;
    r.exp_wen = ew; r.exp_data = ed; r.exp_keep = ek; r.exp_cnt = ec;
    return r;
  endfunction

  initial begin
    int k, cyc, first_low, beats_ok;
    logic fu;

    vecs[0]  = mk(1, 8'h11, 0, 0, 0, 0, 32'h0,        4'h0, 16'd0);
    vecs[1]  = mk(1, 8'h22, 0, 0, 0, 0, 32'h0,        4'h0, 16'd0);
    vecs[2]  = mk(1, 8'h33, 0, 0, 0, 0, 32'h0,        4'h0, 16'd0);
    vecs[3]  = mk(1, 8'h44, 0, 0, 0, 0, 32'h0,        4'h0, 16'd0);
    vecs[4]  = mk(0, 8'h99, 1, 0, 0, 0, 32'h0,        4'h0, 16'd0);
    vecs[5]  = mk(0, 8'h00, 0, 0, 0, 1, 32'h44332211, 4'hF, 16'd0);
    vecs[6]  = mk(0, 8'h00, 0, 0, 0, 0, 32'h0,        4'h0, 16'd1);
    vecs[7]  = mk(1, 8'hAA, 0, 0, 0, 0, 32'h0,        4'h0, 16'd1);
    vecs[8]  = mk(1, 8'hBB, 1, 0, 0, 0, 32'h0,        4'h0, 16'd1);
    vecs[9]  = mk(0, 8'h00, 0, 0, 0, 0, 32'h0,        4'h0, 16'd1);
    vecs[10] = mk(0, 8'h00, 0, 0, 0, 1, 32'h0000BBAA, 4'h3, 16'd1);
    vecs[11] = mk(0, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0, 16'd2);
    vecs[12] = mk(0, 8'h00, 0, 0, 0, 0, 32'h0,        4'h0, 16'd2);
    vecs[13] = mk(1, 8'hCC, 0, 0, 0, 0, 32'h0,        4'h0, 16'd2);
    vecs[14] = mk(0, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0, 16'd2);
    vecs[15] = mk(0, 8'h00, 0, 0, 0, 0, 32'h0,        4'h0, 16'd2);
    vecs[16] = mk(0, 8'h00, 0, 0, 0, 1, 32'h000000CC, 4'h1, 16'd2);
    vecs[17] = mk(1, 8'hDD, 0, 1, 0, 0, 32'h0,        4'h0, 16'd3);
    vecs[18] = mk(0, 8'h00, 0, 0, 0, 0, 32'h0,        4'h0, 16'd3);
    vecs[19] = mk(0, 8'h00, 0, 0, 0, 1, 32'h000000DD, 4'h1, 16'd3);
    vecs[20] = mk(0, 8'h00, 0, 0, 0, 0, 32'h0,        4'h0, 16'd4);
    vecs[21] = mk(1, 8'hEE, 1, 0, 1, 0, 32'h0,        4'h0, 16'd4);
    vecs[22] = mk(0, 8'h00, 0, 0, 1, 0, 32'h0,        4'h0, 16'd4);
    vecs[23] = mk(0, 8'h00, 0, 0, 1, 0, 32'h0,        4'h0, 16'd4);
    vecs[24] = mk(0, 8'h00, 0, 0, 0, 1, 32'h000000EE, 4'h1, 16'd4);
    vecs[25] = mk(0, 8'h00, 0, 0, 0, 0, 32'h0,        4'h0, 16'd5);

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_flush = 1'b0;
    i_full  = 1'b0;
    modelReset();
    #3;
    checkResetOutputs("por");
    repeat (2) @(posedge i_clk_wr);
    @(negedge i_clk_wr);
    i_rst_n = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 26; i++) begin
      driveInputs(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].flush, vecs[i].full);
      checkOutput();
      check($sformatf("vec%0d_wr_en", i), o_wr_en, vecs[i].exp_wen);
      check($sformatf("vec%0d_word_cnt", i), o_word_cnt, vecs[i].exp_cnt);
      if (vecs[i].exp_wen) begin
        check($sformatf("vec%0d_data", i), o_wr_data, vecs[i].exp_data);
        check($sformatf("vec%0d_keep", i), o_wr_keep, vecs[i].exp_keep);
      end
      advance();
    end

    $display("[TB] full backpressure with 12 beats");
    doReset("rst_full");
    k = 0; cyc = 0; first_low = -1;
    while (k < 12 && cyc < 60) begin
      fu = (cyc < 20);
      driveInputs(1'b1, 8'(k + 1), 1'b0, 1'b0, fu);
      checkOutput();
      if (!o_ready && first_low < 0) first_low = k;
      beats_ok = int'(exp_ready);
      advance();
      k += beats_ok;
      cyc++;
    end
    check("full_all_beats_taken", 32'(k), 32'd12);
    check("full_stall_after_beat", 32'(first_low), 32'd8);
    drain(20);
    @(negedge i_clk_wr);
    check("full_word_cnt", o_word_cnt, 16'd3);

    $display("[TB] continuous 64 beats");
    doReset("rst_stream");
    ready_low_cycles = 0;
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    check("stream_ready_low_cycles", 32'(ready_low_cycles), 32'd0);
    drain(20);
    @(negedge i_clk_wr);
    check("stream_word_cnt", o_word_cnt, 16'd16);

    $display("[TB] reset with word pending");
    doReset("rst_pre");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b1);
    doReset("rst_mid");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    driveInputs(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("midrst_wr_en", o_wr_en, 1'b1);
    check("midrst_data", o_wr_data, 32'hA3A2A1A0);
    checkOutput();
    advance();
    drain(10);
    @(negedge i_clk_wr);
    check("midrst_word_cnt", o_word_cnt, 16'd1);

    $display("[TB] random traffic");
    doReset("rst_rand");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0,
                    ($urandom % 10) == 0, ($urandom % 4) == 0);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    drain(20);

    $display("[TB] word counter wrap");
    doReset("rst_wrap");
    for (int i = 0; i < 65535; i++) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    drain(10);
    @(negedge i_clk_wr);
    check("wrap_cnt_max", o_word_cnt, 16'hFFFF);
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    drain(10);
    @(negedge i_clk_wr);
    check("wrap_cnt_zero", o_word_cnt, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
